// File: rtl/weight_stream_buffer_if.sv
// Coefficient stream handshake (ap_fifo style) between a weight streamer
// and the weight_stream_buffer.
//   input_V_dout    : coefficient word, valid while input_V_empty_n=1
//   input_V_empty_n : upstream FIFO holds at least one word
//   input_V_read    : pop strobe driven by the consumer
// master = producer side, slave = consumer side.
interface weight_stream_buffer_if #(
  parameter int COEFF_WIDTH = 16
);
  logic [COEFF_WIDTH-1:0] input_V_dout;
  logic                   input_V_empty_n;
  logic                   input_V_read;

  modport master (
    output input_V_dout,
    output input_V_empty_n,
    input  input_V_read
  );

  modport slave (
    input  input_V_dout,
    input  input_V_empty_n,
    output input_V_read
  );
endinterface

// File: rtl/weight_stream_buffer.sv
// Consumer end of the coefficient stream. Fills a local RAM with one full
// kernel set, then serves single-port random-access reads to the datapath.
// A reload request restarts the fill from address 0.
//   ap_clk, ap_rst : clock (rising edge), async active-high reset
//   strm           : coefficient stream (slave side)
//   reload         : single-cycle refill request
//   rd_address     : read address from the datapath
//   rd_ce          : read enable
//   rd_q           : registered read data, one-cycle latency, read-first
//   loaded         : full kernel set is resident
//   load_count     : words stored in the current load
//
// state  | meaning
// S_LOAD | popping stream words into RAM[wr_ptr]
// S_READY| kernel set complete; stream left untouched
module weight_stream_buffer #(
  parameter int COEFF_WIDTH = 16,
  parameter int KERN_SIZE   = 288,
  parameter int ADDR_WIDTH  = $clog2(KERN_SIZE)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  weight_stream_buffer_if.slave  strm,
  input  logic                   reload,
  input  logic [ADDR_WIDTH-1:0]  rd_address,
  input  logic                   rd_ce,
  output logic [COEFF_WIDTH-1:0] rd_q,
  output logic                   loaded,
  output logic [ADDR_WIDTH:0]    load_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERN_SIZE - 1);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                 state, next_state;
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic                   accept;
  logic                   last_word;
  logic [COEFF_WIDTH-1:0] mem [KERN_SIZE];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_LOAD;
    else        state <= next_state;
  end

  // The pop strobe is gated by reset so it drops immediately on assertion,
  // not at the next edge.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_word  = (wr_ptr == LAST_ADDR);
    case (state)
      S_LOAD: begin
        accept = strm.input_V_empty_n & ~ap_rst;
        if (reload)                  next_state = S_LOAD;
        else if (accept && last_word) next_state = S_READY;
      end
      S_READY: begin
        if (reload) next_state = S_LOAD;
      end
      default: next_state = S_LOAD;
    endcase
  end

  assign strm.input_V_read = accept;
  assign loaded            = (state == S_READY);

  // Reload wins over a same-edge accept: the word still lands in RAM but
  // the pointer and count restart from zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (reload) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (accept) begin
      wr_ptr     <= last_word ? '0 : wr_ptr + 1'b1;
      load_count <= load_count + 1'b1;
    end
  end

  // RAM has no reset; contents survive ap_rst.
  always_ff @(posedge ap_clk) begin
    if (accept) mem[wr_ptr] <= strm.input_V_dout;
  end

  // Non-blocking read of the same array gives read-first behaviour on a
  // same-address write.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)     rd_q <= '0;
    else if (rd_ce) rd_q <= mem[rd_address];
  end

endmodule

// File: tb/tb_weight_stream_buffer.sv
module tb_weight_stream_buffer;
  localparam int CW = 16;
  localparam int KS = 4;
  localparam int AW = 2;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  weight_stream_buffer_if #(.COEFF_WIDTH(CW)) strm ();
  logic          reload;
  logic          rd_ce;
  logic [AW-1:0] rd_address;
  logic [CW-1:0] rd_q;
  logic          loaded;
  logic [AW:0]   load_count;

  weight_stream_buffer #(.COEFF_WIDTH(CW), .KERN_SIZE(KS), .ADDR_WIDTH(AW)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .strm       (strm),
    .reload     (reload),
    .rd_address (rd_address),
    .rd_ce      (rd_ce),
    .rd_q       (rd_q),
    .loaded     (loaded),
    .load_count (load_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words stored so far, a loaded flag, and an image of RAM.
  logic [CW-1:0] m_mem [KS];
  int            m_count;
  bit            m_loaded;
  logic [CW-1:0] m_rdq;
  logic          obs_read;
  bit            exp_read;

  task automatic model_reset();
    m_count  = 0;
    m_loaded = 1'b0;
    m_rdq    = '0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), sample the pop strobe at
  // the negedge, update the model at the posedge, return at posedge+1.
  task automatic step(input bit en, input logic [CW-1:0] d, input bit rl,
                      input bit ce, input logic [AW-1:0] a);
    strm.input_V_empty_n = en;
    strm.input_V_dout    = d;
    reload               = rl;
    rd_ce                = ce;
    rd_address           = a;
    @(negedge ap_clk);
    obs_read = strm.input_V_read;
    exp_read = !m_loaded && en;
    @(posedge ap_clk);
    if (ce) m_rdq = m_mem[int'(a)];
    if (exp_read) m_mem[m_count] = d;
    if (rl) begin
      m_count  = 0;
      m_loaded = 1'b0;
    end else if (exp_read) begin
      m_count++;
      if (m_count == KS) m_loaded = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    strm.input_V_empty_n = 1'b1;
    strm.input_V_dout = '0;
    reload = 1'b0; rd_ce = 1'b0; rd_address = '0;
    model_reset();
    #12;
    checks++; if (strm.input_V_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", strm.input_V_read); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %b want 0", loaded); end
    checks++; if (rd_q !== '0) begin errors++; $display("FAIL reset_rdq got %h want 0", rd_q); end
    checks++; if (load_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", load_count); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #2;
    checks++; if (strm.input_V_read !== 1'b1) begin errors++; $display("FAIL release_read got %b want 1", strm.input_V_read); end
    strm.input_V_empty_n = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] words [4];
    words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0, '0);
      checks++; if (obs_read !== 1'b1) begin errors++; $display("FAIL b2b_read[%0d] got %b want 1", i, obs_read); end
      checks++; if (load_count !== 3'(i + 1)) begin errors++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, load_count, i + 1); end
      checks++; if (loaded !== (i == 3)) begin errors++; $display("FAIL b2b_loaded[%0d] got %b want %b", i, loaded, i == 3); end
    end
    step(1'b1, 16'h0055, 1'b0, 1'b0, '0);
    checks++; if (obs_read !== 1'b0) begin errors++; $display("FAIL b2b_extra_read got %b want 0", obs_read); end
    checks++; if (load_count !== 3'(KS)) begin errors++; $display("FAIL b2b_hold_count got %0d want %0d", load_count, KS); end
  endtask

  task automatic test_readback();
    logic [AW-1:0] addrs [4];
    logic [CW-1:0] want [4];
    addrs = '{2'd3, 2'd0, 2'd2, 2'd1};
    want  = '{16'h0044, 16'h0011, 16'h0033, 16'h0022};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, addrs[i]);
      checks++; if (rd_q !== want[i] || rd_q !== m_rdq) begin errors++; $display("FAIL readback[%0d] got %h want %h", i, rd_q, want[i]); end
    end
    step(1'b0, '0, 1'b0, 1'b0, 2'd2);
    checks++; if (rd_q !== 16'h0022) begin errors++; $display("FAIL readback_hold got %h want 0022", rd_q); end
  endtask

  task automatic test_reload();
    step(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (loaded !== 1'b0 || load_count !== '0) begin errors++; $display("FAIL reload_drop got loaded=%b count=%0d want 0/0", loaded, load_count); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, CW'(16'h000A + i), 1'b0, 1'b0, '0);
      checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL reload_loaded[%0d] got %b want %b", i, loaded, m_loaded); end
    end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reload_done got %b want 1", loaded); end
    step(1'b0, '0, 1'b0, 1'b1, 2'd0);
    checks++; if (rd_q !== 16'h000A) begin errors++; $display("FAIL reload_rd0 got %h want 000a", rd_q); end
  endtask

  task automatic test_bubbly();
    bit pat [7];
    int want_cnt [7];
    pat      = '{1, 0, 0, 1, 1, 0, 1};
    want_cnt = '{1, 1, 1, 2, 3, 3, 4};
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin
      step(pat[i], CW'($urandom), 1'b0, 1'b0, '0);
      checks++; if (obs_read !== pat[i]) begin errors++; $display("FAIL bubbly_read[%0d] got %b want %b", i, obs_read, pat[i]); end
      checks++; if (load_count !== 3'(want_cnt[i])) begin errors++; $display("FAIL bubbly_count[%0d] got %0d want %0d", i, load_count, want_cnt[i]); end
    end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL bubbly_loaded got %b want 1", loaded); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, AW'(i));
      checks++; if (rd_q !== m_rdq) begin errors++; $display("FAIL bubbly_rd[%0d] got %h want %h", i, rd_q, m_rdq); end
    end
  endtask

  task automatic test_abort();
    logic [CW-1:0] words [4];
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, '0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, '0);
    checks++; if (load_count !== 3'd2) begin errors++; $display("FAIL abort_mid got %0d want 2", load_count); end
    step(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (load_count !== '0) begin errors++; $display("FAIL abort_count got %0d want 0", load_count); end
    for (int i = 0; i < 4; i++) begin
      words[i] = CW'($urandom);
      step(1'b1, words[i], 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, AW'(i));
      checks++; if (rd_q !== words[i]) begin errors++; $display("FAIL abort_rd[%0d] got %h want %h", i, rd_q, words[i]); end
    end
  endtask

  task automatic test_reload_final();
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, CW'($urandom), 1'b0, 1'b0, '0);
    step(1'b1, CW'($urandom), 1'b1, 1'b0, '0);
    checks++; if (obs_read !== 1'b1) begin errors++; $display("FAIL final_read got %b want 1", obs_read); end
    checks++; if (loaded !== 1'b0 || load_count !== '0) begin errors++; $display("FAIL final_reload got loaded=%b count=%0d want 0/0", loaded, load_count); end
    step(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL final_stay got %b want 0", loaded); end
  endtask

  task automatic test_rst_mid();
    step(1'b1, CW'($urandom), 1'b0, 1'b0, '0);
    step(1'b1, CW'($urandom), 1'b0, 1'b0, '0);
    strm.input_V_empty_n = 1'b1;
    reload = 1'b0; rd_ce = 1'b0;
    #2;
    checks++; if (strm.input_V_read !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", strm.input_V_read); end
    ap_rst = 1'b1;
    #1;
    checks++; if (strm.input_V_read !== 1'b0) begin errors++; $display("FAIL rstmid_read got %b want 0", strm.input_V_read); end
    checks++; if (load_count !== '0 || loaded !== 1'b0 || rd_q !== '0) begin errors++; $display("FAIL rstmid_state got count=%0d loaded=%b rdq=%h want 0/0/0", load_count, loaded, rd_q); end
    model_reset();
    strm.input_V_empty_n = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 4; i++) step(1'b1, CW'($urandom), 1'b0, 1'b0, '0);
    checks++; if (loaded !== 1'b1 || load_count !== 3'(KS)) begin errors++; $display("FAIL rstmid_reload got loaded=%b count=%0d want 1/%0d", loaded, load_count, KS); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, KS - 1)));
      checks++; if (obs_read !== exp_read) begin errors++; $display("FAIL rnd_read[%0d] got %b want %b", i, obs_read, exp_read); end
      checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL rnd_loaded[%0d] got %b want %b", i, loaded, m_loaded); end
      checks++; if (load_count !== 3'(m_count)) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, load_count, m_count); end
      if (!$isunknown(m_rdq)) begin
        checks++; if (rd_q !== m_rdq) begin errors++; $display("FAIL rnd_rdq[%0d] got %h want %h", i, rd_q, m_rdq); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_readback();
    test_reload();
    test_bubbly();
    test_abort();
    test_reload_final();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
